systolic_frame_sched: RTL
=========================

SYSTOLIC_FRAME_SCHED -- requirements
Module: systolic_frame_sched

Interface
REQ-001 SHALL have parameter BLOCK_LEN, default 16, beats per frame; the value is fixed at 16 in this revision.
REQ-002 SHALL have port clk  in  1  the only clock; all logic on posedge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port en  in  1  run request from the top-level enable.
REQ-005 SHALL have port mark_in  in  1  frame marker; high on beat 0 of each input frame.
REQ-006 SHALL have port wr_en  out  1  capture strobe to the input buffer.
REQ-007 SHALL have port wr_idx  out  4  input buffer slot for this beat.
REQ-008 SHALL have port swap  out  1  pulse: swap input and output buffers, and clear input.
REQ-009 SHALL have port rd_valid  out  1  output buffer holds a complete frame.
REQ-010 SHALL have port rd_idx  out  4  output buffer slot to drive this beat.
REQ-011 SHALL have port busy  out  1  high when the state is not IDLE.
REQ-012 SHALL have port sync_err  out  1  one-cycle pulse on a marker loss.
REQ-013 SHALL have port frame_cnt  out  8  completed swaps, wrapping at 255.

Function
REQ-014 SHALL implement an FSM with states IDLE, HUNT, RUN and DRAIN, plus a 4-bit beat counter beat and a flag full.
REQ-015 SHALL move from IDLE to HUNT on the cycle after en is sampled high.
REQ-016 SHALL, in HUNT with mark_in=1, assert wr_en with wr_idx=0 combinationally, then set beat<=1 and enter RUN; with mark_in=0, hold.
REQ-017 SHALL, in RUN, drive wr_en=1 and wr_idx=beat, and increment beat by 1 per cycle, wrapping 15 to 0.
REQ-018 SHALL, in RUN at beat==15, assert swap for that cycle, set full<=1, and increment frame_cnt.
REQ-019 SHALL, in RUN at beat==0 with mark_in=0, drive wr_en=0, pulse sync_err on the next cycle, clear full and beat, and enter HUNT.
REQ-020 SHALL ignore mark_in=1 at any nonzero beat.
REQ-021 SHALL drive rd_idx=beat and rd_valid=full&&(RUN||DRAIN), so the output lags the input by exactly one frame.
REQ-022 SHALL, when en is low in RUN, finish the frame through beat 15 (swap included) and then enter DRAIN with beat=0.
REQ-023 SHALL, when en falls at beat 15, treat it the same as REQ-022.
REQ-024 SHALL, in DRAIN, drive wr_en=0 and rd_valid=1 for 16 beats, then clear full and enter IDLE; en is ignored during DRAIN.
REQ-025 SHALL, when en is low in HUNT, return to IDLE on the next cycle.
REQ-026 SHALL hold all outputs except busy at 0 in IDLE.

Reset
REQ-027 SHALL, on rst=1 at a posedge, force state=IDLE, beat=0, full=0, frame_cnt=0 and sync_err=0, overriding every other event.
REQ-028 SHALL, when reset occurs mid-frame, discard the partial frame and issue no swap.

Configuration
REQ-029 SHALL, with SYSTOLIC_SCHED_MARK_CHECK_EN defined, apply REQ-019 marker checking.
REQ-030 SHALL, without SYSTOLIC_SCHED_MARK_CHECK_EN, omit REQ-019, tie sync_err to 0, and stay in RUN regardless of mark_in after lock.

Structure
REQ-031 SHALL take the BLOCK_LEN and beat-width constants and the state enum from the shared package systolic_pkg.
REQ-032 SHALL place the beat counter (increment, wrap and clear) in the sub-module systolic_beat_ctr; all other logic SHALL stay flat.

Verification
REQ-033 SHALL cover lock: en=1, mark_in high on cycle 5 -> wr_en=1 and wr_idx=0 on cycle 5, swap on cycle 20, rd_valid from cycle 21.
REQ-034 SHALL cover steady state: 3 frames with a correct marker -> 3 swap pulses spaced 16 cycles apart, frame_cnt=3, sync_err never high.
REQ-035 SHALL cover marker loss: mark_in=0 at beat 0 of frame 2 -> wr_en=0 that cycle, sync_err pulse on the next cycle, state HUNT, rd_valid=0.
REQ-036 SHALL cover drain: en falls at beat 7 -> beats 8-15 still written, swap at beat 15, then 16 beats with rd_valid=1 and wr_en=0, then busy=0.
REQ-037 SHALL cover reset mid-frame: rst at beat 9 -> next cycle busy=0, full=0, frame_cnt=0, and no swap.
REQ-038 SHALL cover frame_cnt wrap: 256 frames -> frame_cnt returns to 0.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared constants and state encoding for the systolic frame scheduler.
package systolic_pkg;

    localparam int DEF_BLOCK_LEN = 16;
    localparam int BEAT_W        = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HUNT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/systolic_frame_sched_if.sv
// Bus between the frame scheduler and its host: run/marker inputs and
// buffer control outputs. The scheduler uses the slave modport.
interface systolic_frame_sched_if;
    import systolic_pkg::*;

    logic              en;
    logic              mark_in;
    logic              wr_en;
    logic [BEAT_W-1:0] wr_idx;
    logic              swap;
    logic              rd_valid;
    logic [BEAT_W-1:0] rd_idx;
    logic              busy;
    logic              sync_err;
    logic [7:0]        frame_cnt;

    modport master (
        output en, mark_in,
        input  wr_en, wr_idx, swap, rd_valid, rd_idx, busy, sync_err, frame_cnt
    );

    modport slave (
        input  en, mark_in,
        output wr_en, wr_idx, swap, rd_valid, rd_idx, busy, sync_err, frame_cnt
    );

endinterface

// File: rtl/systolic_beat_ctr.sv
// Beat counter for the frame scheduler. Clear has priority over increment,
// so clr together with inc loads 1 (used when locking on a marker).
module systolic_beat_ctr
    import systolic_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [BEAT_W-1:0] beat
);

    logic [BEAT_W-1:0] beat_r;

    // Beat register: wraps naturally from all-ones to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_r <= {BEAT_W{1'b0}};
        end else if (clr) begin
            beat_r <= {{(BEAT_W-1){1'b0}}, inc};
        end else if (inc) begin
            beat_r <= beat_r + {{(BEAT_W-1){1'b0}}, 1'b1};
        end else begin
            beat_r <= beat_r;
        end
    end

    assign beat = beat_r;

endmodule

// File: rtl/systolic_frame_sched.sv
// Double-buffered frame scheduler: locks on a frame marker, writes one frame
// while reading the previous one. Define SYSTOLIC_SCHED_MARK_CHECK_EN to re-hunt on marker loss.
module systolic_frame_sched
    import systolic_pkg::*;
#(
    parameter int BLOCK_LEN = DEF_BLOCK_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    systolic_frame_sched_if.slave bus
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_LEN - 1);

    state_t            state_r, state_s;
    logic              full_r, full_s;
    logic              stop_r, stop_s;
    logic [7:0]        frame_cnt_r, frame_cnt_s;
    logic [BEAT_W-1:0] beat_s;
    logic [BEAT_W-1:0] wr_idx_s;
    logic              beat_clr_s, beat_inc_s, wr_en_s, swap_s, mark_lost_s;

    systolic_beat_ctr u_beat_ctr (
        .clk  (clk),
        .rst  (rst),
        .clr  (beat_clr_s),
        .inc  (beat_inc_s),
        .beat (beat_s)
    );

`ifdef SYSTOLIC_SCHED_MARK_CHECK_EN
    logic sync_err_r;
    assign mark_lost_s = (beat_s == {BEAT_W{1'b0}}) && !bus.mark_in;

    // Marker-loss pulse, one cycle after the missing beat-0 marker
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_err_r <= 1'b0;
        end else begin
            sync_err_r <= (state_r == ST_RUN) && mark_lost_s;
        end
    end
    assign bus.sync_err = sync_err_r;
`else
    assign mark_lost_s  = 1'b0;
    assign bus.sync_err = 1'b0;
`endif

    // Next state, beat control and write-side strobes
    always_comb begin
        state_s     = state_r;
        full_s      = full_r;
        stop_s      = stop_r;
        frame_cnt_s = frame_cnt_r;
        beat_clr_s  = 1'b0;
        beat_inc_s  = 1'b0;
        wr_en_s     = 1'b0;
        wr_idx_s    = {BEAT_W{1'b0}};
        swap_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                stop_s     = 1'b0;
                beat_clr_s = 1'b1;
                if (bus.en) state_s = ST_HUNT;
                else        state_s = ST_IDLE;
            end
            ST_HUNT: begin
                stop_s     = 1'b0;
                beat_clr_s = 1'b1;
                if (!bus.en) begin
                    state_s = ST_IDLE;
                end else if (bus.mark_in) begin
                    wr_en_s    = 1'b1;
                    beat_inc_s = 1'b1;
                    state_s    = ST_RUN;
                end else begin
                    state_s = ST_HUNT;
                end
            end
            ST_RUN: begin
                if (mark_lost_s) begin
                    full_s     = 1'b0;
                    stop_s     = 1'b0;
                    beat_clr_s = 1'b1;
                    state_s    = ST_HUNT;
                end else begin
                    wr_en_s    = 1'b1;
                    wr_idx_s   = beat_s;
                    beat_inc_s = 1'b1;
                    if (beat_s == LAST_BEAT) begin
                        // A stop request seen anywhere in the frame takes effect here
                        swap_s      = 1'b1;
                        full_s      = 1'b1;
                        frame_cnt_s = frame_cnt_r + 8'd1;
                        stop_s      = 1'b0;
                        if (stop_r || !bus.en) state_s = ST_DRAIN;
                        else                   state_s = ST_RUN;
                    end else begin
                        stop_s  = stop_r | ~bus.en;
                        state_s = ST_RUN;
                    end
                end
            end
            ST_DRAIN: begin
                stop_s     = 1'b0;
                beat_inc_s = 1'b1;
                if (beat_s == LAST_BEAT) begin
                    full_s  = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                full_s     = 1'b0;
                stop_s     = 1'b0;
                beat_clr_s = 1'b1;
            end
        endcase
    end

    // Control state registers; reset overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            full_r      <= 1'b0;
            stop_r      <= 1'b0;
            frame_cnt_r <= 8'd0;
        end else begin
            state_r     <= state_s;
            full_r      <= full_s;
            stop_r      <= stop_s;
            frame_cnt_r <= frame_cnt_s;
        end
    end

    // IDLE presents every output except busy as zero, including the count
    assign bus.wr_en     = wr_en_s;
    assign bus.wr_idx    = wr_idx_s;
    assign bus.swap      = swap_s;
    assign bus.rd_valid  = full_r && ((state_r == ST_RUN) || (state_r == ST_DRAIN));
    assign bus.rd_idx    = (state_r == ST_IDLE) ? {BEAT_W{1'b0}} : beat_s;
    assign bus.busy      = (state_r != ST_IDLE);
    assign bus.frame_cnt = (state_r == ST_IDLE) ? 8'd0 : frame_cnt_r;

endmodule
